ec_scalar_mult_ctrl: RTL and testbench



---
 rtl/ecc_pkg.sv | 24 ++
 rtl/ec_scalar_mult_ctrl.sv | 241 ++++++++++++++++++++++++
 tb/tb_ec_scalar_mult_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_pkg.sv
// Shared constants and controller state encoding for the ECC scalar-multiply path.
package ecc_pkg;

    localparam int WIDTH = 192;

    // Point at infinity is carried as (INF_X, 0).
    localparam logic [WIDTH-1:0] INF_X = {WIDTH{1'b1}};

    localparam logic OP_DBL = 1'b1;
    localparam logic OP_ADD = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_SCAN     = 4'd1,
        ST_DBL_REQ  = 4'd2,
        ST_DBL_WAIT = 4'd3,
        ST_BIT      = 4'd4,
        ST_ADD_REQ  = 4'd5,
        ST_ADD_WAIT = 4'd6,
        ST_NEXT     = 4'd7,
        ST_DONE     = 4'd8
    } state_e;

endpackage

// File: rtl/ec_scalar_mult_ctrl.sv
// Left-to-right double-and-add controller: scans k MSB first and drives the
// point double/add engine through a start/finish handshake, feeding each
// engine result back as the next running point Q.
module ec_scalar_mult_ctrl
    import ecc_pkg::*;
#(
    parameter int WIDTH = ecc_pkg::WIDTH,
    parameter int IDXW  = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_k,
    input  logic [WIDTH-1:0] i_px,
    input  logic [WIDTH-1:0] i_py,
    output logic             o_busy,
    output logic             o_finished,
    output logic [WIDTH-1:0] o_rx,
    output logic [WIDTH-1:0] o_ry,
    output logic             o_infinity,
    output logic             o_op_start,
    output logic             o_op_dbl,
    output logic [WIDTH-1:0] o_op_x1,
    output logic [WIDTH-1:0] o_op_y1,
    output logic [WIDTH-1:0] o_op_x2,
    output logic [WIDTH-1:0] o_op_y2,
    input  logic             i_op_finish,
    input  logic [WIDTH-1:0] i_op_x,
    input  logic [WIDTH-1:0] i_op_y
);

    localparam logic [WIDTH-1:0] INF_PT_X = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
    localparam logic [IDXW-1:0]  IDX_TOP  = IDXW'(WIDTH - 1);
    localparam logic [IDXW-1:0]  IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0]  IDX_ONE  = {{(IDXW-1){1'b0}}, 1'b1};

    // Engine results whose x is INF_X collapse onto the canonical (INF_X, 0).
    function automatic logic [WIDTH-1:0] norm_y(input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
        return (x == INF_PT_X) ? ZERO_W : y;
    endfunction

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d;
    logic [WIDTH-1:0] k_q, k_d, px_q, px_d, py_q, py_d, qx_q, qx_d, qy_q, qy_d;
    logic             op_start_q, op_start_d, op_dbl_q, op_dbl_d;
    logic [WIDTH-1:0] op_x1_q, op_x1_d, op_y1_q, op_y1_d, op_x2_q, op_x2_d, op_y2_q, op_y2_d;
    logic [WIDTH-1:0] rx_q, rx_d, ry_q, ry_d;
    logic             inf_q, inf_d, fin_q, fin_d;

    // State register and datapath registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            idx_q      <= IDX_ZERO;
            k_q        <= ZERO_W;
            px_q       <= ZERO_W;
            py_q       <= ZERO_W;
            qx_q       <= ZERO_W;
            qy_q       <= ZERO_W;
            op_start_q <= 1'b0;
            op_dbl_q   <= 1'b0;
            op_x1_q    <= ZERO_W;
            op_y1_q    <= ZERO_W;
            op_x2_q    <= ZERO_W;
            op_y2_q    <= ZERO_W;
            rx_q       <= ZERO_W;
            ry_q       <= ZERO_W;
            inf_q      <= 1'b0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            k_q        <= k_d;
            px_q       <= px_d;
            py_q       <= py_d;
            qx_q       <= qx_d;
            qy_q       <= qy_d;
            op_start_q <= op_start_d;
            op_dbl_q   <= op_dbl_d;
            op_x1_q    <= op_x1_d;
            op_y1_q    <= op_y1_d;
            op_x2_q    <= op_x2_d;
            op_y2_q    <= op_y2_d;
            rx_q       <= rx_d;
            ry_q       <= ry_d;
            inf_q      <= inf_d;
            fin_q      <= fin_d;
        end
    end

    // Next-state and datapath updates; pulses default low, everything else holds.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        k_d        = k_q;
        px_d       = px_q;
        py_d       = py_q;
        qx_d       = qx_q;
        qy_d       = qy_q;
        op_start_d = 1'b0;
        op_dbl_d   = op_dbl_q;
        op_x1_d    = op_x1_q;
        op_y1_d    = op_y1_q;
        op_x2_d    = op_x2_q;
        op_y2_d    = op_y2_q;
        rx_d       = rx_q;
        ry_d       = ry_q;
        inf_d      = inf_q;
        fin_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    k_d     = i_k;
                    px_d    = i_px;
                    py_d    = i_py;
                    idx_d   = IDX_TOP;
                    state_d = ST_SCAN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SCAN: begin
                if (k_q[idx_q]) begin
                    // Leading one found: Q starts as P.
                    qx_d = px_q;
                    qy_d = py_q;
                    if (idx_q == IDX_ZERO) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_ONE;
                        state_d = ST_DBL_REQ;
                    end
                end else if (idx_q == IDX_ZERO) begin
                    qx_d    = INF_PT_X;
                    qy_d    = ZERO_W;
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q - IDX_ONE;
                end
            end
            ST_DBL_REQ: begin
                if (qx_q == INF_PT_X) begin
                    // Doubling infinity is infinity; no engine call.
                    state_d = ST_BIT;
                end else begin
                    op_start_d = 1'b1;
                    op_dbl_d   = OP_DBL;
                    op_x1_d    = qx_q;
                    op_y1_d    = qy_q;
                    state_d    = ST_DBL_WAIT;
                end
            end
            ST_DBL_WAIT: begin
                if (i_op_finish) begin
                    qx_d    = i_op_x;
                    qy_d    = norm_y(i_op_x, i_op_y);
                    state_d = ST_BIT;
                end else begin
                    state_d = ST_DBL_WAIT;
                end
            end
            ST_BIT: begin
                if (k_q[idx_q]) begin
                    state_d = ST_ADD_REQ;
                end else begin
                    state_d = ST_NEXT;
                end
            end
            ST_ADD_REQ: begin
                if (qx_q == INF_PT_X) begin
                    qx_d    = px_q;
                    qy_d    = py_q;
                    state_d = ST_NEXT;
                end else if ((qx_q == px_q) && (qy_q != py_q)) begin
                    // Q = -P: the sum is the point at infinity.
                    qx_d    = INF_PT_X;
                    qy_d    = ZERO_W;
                    state_d = ST_NEXT;
                end else if (qx_q == px_q) begin
                    // Q = P: the add formula degenerates, so request a double.
                    op_start_d = 1'b1;
                    op_dbl_d   = OP_DBL;
                    op_x1_d    = px_q;
                    op_y1_d    = py_q;
                    state_d    = ST_ADD_WAIT;
                end else begin
                    op_start_d = 1'b1;
                    op_dbl_d   = OP_ADD;
                    op_x1_d    = qx_q;
                    op_y1_d    = qy_q;
                    op_x2_d    = px_q;
                    op_y2_d    = py_q;
                    state_d    = ST_ADD_WAIT;
                end
            end
            ST_ADD_WAIT: begin
                if (i_op_finish) begin
                    qx_d    = i_op_x;
                    qy_d    = norm_y(i_op_x, i_op_y);
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_ADD_WAIT;
                end
            end
            ST_NEXT: begin
                if (idx_q == IDX_ZERO) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = idx_q - IDX_ONE;
                    state_d = ST_DBL_REQ;
                end
            end
            ST_DONE: begin
                rx_d    = qx_q;
                ry_d    = qy_q;
                inf_d   = (qx_q == INF_PT_X);
                fin_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy     = (state_q != ST_IDLE);
    assign o_finished = fin_q;
    assign o_rx       = rx_q;
    assign o_ry       = ry_q;
    assign o_infinity = inf_q;
    assign o_op_start = op_start_q;
    assign o_op_dbl   = op_dbl_q;
    assign o_op_x1    = op_x1_q;
    assign o_op_y1    = op_y1_q;
    assign o_op_x2    = op_x2_q;
    assign o_op_y2    = op_y2_q;

endmodule

// File: tb/tb_ec_scalar_mult_ctrl.sv
// Scoreboard bench for ec_scalar_mult_ctrl with a fixed-latency mock engine
// whose results come from a per-run response table.
module tb_ec_scalar_mult_ctrl;
    import ecc_pkg::*;

    localparam int LAT = 5;
    localparam int TAB = 512;

    typedef logic [WIDTH-1:0] w_t;
    typedef struct { logic dbl; w_t x1; w_t y1; w_t x2; w_t y2; } req_t;
    typedef struct { w_t rx; w_t ry; logic inf; int nreq; int lat; } res_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, start;
    w_t   k, px, py;
    logic busy, fin, inf, op_start, op_dbl;
    w_t   rx, ry, x1, y1, x2, y2;
    logic eng_fin = 1'b0, spur_fin = 1'b0, op_finish;
    w_t   eng_x = '0, eng_y = '0;
    assign op_finish = eng_fin | spur_fin;

    ec_scalar_mult_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_k(k), .i_px(px), .i_py(py),
        .o_busy(busy), .o_finished(fin), .o_rx(rx), .o_ry(ry), .o_infinity(inf),
        .o_op_start(op_start), .o_op_dbl(op_dbl), .o_op_x1(x1), .o_op_y1(y1),
        .o_op_x2(x2), .o_op_y2(y2), .i_op_finish(op_finish), .i_op_x(eng_x), .i_op_y(eng_y)
    );

    int tests = 0, fails = 0;
    int cyc = 0, rst_cnt = 0, start_cyc = 0, done_cnt = 0;
    int req_total = 0, req_base = 0, eng_total = 0, eng_base = 0;
    w_t last_exp_rx = '0;
    req_t req_q[$];
    res_t res_q[$];
    w_t tab_x[TAB];
    w_t tab_y[TAB];

    task automatic check_w(input string nm, input w_t act, input w_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_i(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic w_t rand_w();
        w_t v = '0;
        for (int i = 0; i < WIDTH; i += 32) v = (v << 32) | w_t'($urandom());
        return v;
    endfunction

    // cycle counter and count of clock edges seen with reset asserted
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rst_n) rst_cnt <= rst_cnt + 1;
    end

    // mock engine: fixed latency, answers from the table, checks operands stay put
    logic eng_busy = 1'b0, eng_ovl = 1'b0, eng_dbl = 1'b0;
    int   eng_cnt = 0, eng_rst0 = 0;
    w_t   c_x1, c_y1, c_x2, c_y2;
    always @(negedge clk) begin
        eng_fin = 1'b0;
        if (eng_busy) begin
            if (op_start) eng_ovl = 1'b1;
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                eng_x    = tab_x[(eng_total - eng_base) % TAB];
                eng_y    = tab_y[(eng_total - eng_base) % TAB];
                eng_total = eng_total + 1;
                eng_fin  = 1'b1;
                eng_busy = 1'b0;
                if (rst_cnt == eng_rst0) begin
                    tests++;
                    if (eng_ovl || op_dbl !== eng_dbl || x1 !== c_x1 || y1 !== c_y1 ||
                        (!eng_dbl && (x2 !== c_x2 || y2 !== c_y2))) begin
                        fails++;
                        $display("FAIL operand_hold: overlap=%0d got x1=%h expected x1=%h",
                                 eng_ovl, x1, c_x1);
                    end
                end
            end
        end else if (op_start) begin
            eng_busy = 1'b1;
            eng_cnt  = LAT;
            eng_ovl  = 1'b0;
            eng_dbl  = op_dbl;
            eng_rst0 = rst_cnt;
            c_x1 = x1; c_y1 = y1; c_x2 = x2; c_y2 = y2;
        end
    end

    // request monitor: each engine request must match the next expected one
    always @(negedge clk) begin
        if (op_start) begin
            req_t e;
            req_total = req_total + 1;
            tests++;
            if (req_q.size() == 0) begin
                fails++;
                $display("FAIL req_unexpected: got dbl=%0d x1=%h expected no request", op_dbl, x1);
            end else begin
                e = req_q.pop_front();
                if (op_dbl !== e.dbl || x1 !== e.x1 || y1 !== e.y1 ||
                    (!e.dbl && (x2 !== e.x2 || y2 !== e.y2))) begin
                    fails++;
                    $display("FAIL req_match: got dbl=%0d x1=%h x2=%h expected dbl=%0d x1=%h x2=%h",
                             op_dbl, x1, x2, e.dbl, e.x1, e.x2);
                end
            end
        end
    end

    // result monitor: pops the scoreboard on every completion pulse
    always @(negedge clk) begin
        if (fin) begin
            res_t e;
            done_cnt = done_cnt + 1;
            if (res_q.size() == 0) begin
                check_i("res_unexpected", 1, 0);
            end else begin
                e = res_q.pop_front();
                last_exp_rx = e.rx;
                check_w("rx", rx, e.rx);
                check_w("ry", ry, e.ry);
                check_i("infinity", int'(inf), int'(e.inf));
                check_i("nreq", req_total - req_base, e.nreq);
                if (e.lat >= 0) check_i("latency", cyc - start_cyc, e.lat);
            end
        end
    end

    task automatic resp(input int n, output w_t x, output w_t y);
        x = tab_x[n];
        y = (x == INF_X) ? '0 : tab_y[n];
    endtask

    // reference model: plain MSB-first double-and-add over the response table
    task automatic run(input w_t kk, input w_t ppx, input w_t ppy, input int lat);
        res_t r;
        req_t q;
        w_t   qx, qy;
        int   t = -1;
        int   n = 0;
        for (int i = WIDTH - 1; i >= 0; i--) if (kk[i] && t < 0) t = i;
        if (t < 0) begin
            qx = INF_X; qy = '0;
        end else begin
            qx = ppx; qy = ppy;
            for (int i = t - 1; i >= 0; i--) begin
                if (qx != INF_X) begin
                    q.dbl = 1'b1; q.x1 = qx; q.y1 = qy; q.x2 = '0; q.y2 = '0;
                    req_q.push_back(q);
                    resp(n, qx, qy); n++;
                end
                if (kk[i]) begin
                    if (qx == INF_X) begin
                        qx = ppx; qy = ppy;
                    end else if (qx == ppx && qy != ppy) begin
                        qx = INF_X; qy = '0;
                    end else begin
                        q.dbl = (qx == ppx); q.x1 = qx; q.y1 = qy; q.x2 = ppx; q.y2 = ppy;
                        req_q.push_back(q);
                        resp(n, qx, qy); n++;
                    end
                end
            end
        end
        r.rx = qx; r.ry = qy; r.inf = (qx == INF_X); r.nreq = n; r.lat = lat;
        res_q.push_back(r);
        @(negedge clk);
        req_base = req_total;
        eng_base = eng_total;
        start = 1'b1; k = kk; px = ppx; py = ppy;
        start_cyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int d0 = done_cnt;
        int c = 0;
        while (done_cnt == d0 && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (done_cnt == d0) check_i("done_timeout", 0, 1);
    endtask

    task automatic wait_req(input logic want_add, input int limit);
        int c = 0;
        while (!(op_start && (!want_add || !op_dbl)) && c < limit) begin
            @(negedge clk);
            c++;
        end
        if (c >= limit) check_i("req_timeout", 0, 1);
    endtask

    task automatic check_reset();
        check_i("rst_ctrl", int'({busy, fin, inf, op_start, op_dbl}), 0);
        check_w("rst_data", rx | ry | x1 | y1 | x2 | y2, '0);
    endtask

    task automatic fill_tag();
        for (int n = 0; n < TAB; n++) begin
            tab_x[n] = w_t'(1000 + n);
            tab_y[n] = w_t'(2000 + n);
        end
    endtask

    task automatic fill_rand(input w_t ppx, input w_t ppy);
        for (int n = 0; n < TAB; n++) begin
            case ($urandom_range(0, 9))
                0: begin tab_x[n] = INF_X; tab_y[n] = rand_w(); end
                1: begin tab_x[n] = ppx;   tab_y[n] = ppy; end
                2: begin tab_x[n] = ppx;   tab_y[n] = ppy ^ w_t'(1); end
                default: begin tab_x[n] = rand_w(); tab_y[n] = rand_w(); end
            endcase
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        w_t rpx, rpy, rk;
        rst_n = 1'b0; start = 1'b0; k = '0; px = '0; py = '0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;

        fill_tag();
        run(w_t'(0), w_t'(7), w_t'(9), WIDTH + 1);
        wait_done(20000);
        run(w_t'(1), w_t'(7), w_t'(9), WIDTH + 1);
        wait_done(20000);
        run(w_t'(11), w_t'(100), w_t'(200), -1);
        wait_done(20000);

        // doubles returning infinity mid-scan
        fill_tag(); tab_x[0] = INF_X; tab_y[0] = w_t'(5);
        run(w_t'(6), w_t'(100), w_t'(200), -1);
        wait_done(20000);
        run(w_t'(10), w_t'(100), w_t'(200), -1);
        wait_done(20000);

        // Q = P at the add step, then Q = -P at the add step
        fill_tag(); tab_x[0] = w_t'(100); tab_y[0] = w_t'(200);
        run(w_t'(3), w_t'(100), w_t'(200), -1);
        wait_done(20000);
        fill_tag(); tab_x[0] = w_t'(100); tab_y[0] = w_t'(201);
        run(w_t'(3), w_t'(100), w_t'(200), -1);
        wait_done(20000);

        // start pulse while the double is outstanding must be ignored
        fill_tag();
        run(w_t'(11), w_t'(300), w_t'(400), -1);
        wait_req(1'b0, 2000);
        @(negedge clk);
        start = 1'b1; k = '1; px = w_t'(55); py = w_t'(66);
        @(negedge clk);
        start = 1'b0;
        wait_done(20000);

        // spurious engine finish while idle
        @(negedge clk); spur_fin = 1'b1;
        @(negedge clk); spur_fin = 1'b0;
        @(negedge clk);
        check_i("spur_idle", int'({busy, fin}), 0);
        check_w("spur_rx", rx, last_exp_rx);

        // one-cycle reset during ADD_WAIT abandons the run
        fill_tag();
        run(w_t'(7), w_t'(100), w_t'(200), -1);
        wait_req(1'b1, 2000);
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        res_q.delete();
        req_q.delete();
        check_reset();
        repeat (12) @(negedge clk);
        check_i("late_finish_idle", int'(busy), 0);
        fill_tag();
        run(w_t'(2), w_t'(100), w_t'(200), -1);
        wait_done(20000);

        // randomized runs: full-width and short scalars over adversarial tables
        for (int r = 0; r < 8; r++) begin
            rpx = rand_w(); rpy = rand_w(); rk = rand_w();
            if (r >= 4) rk = rk & w_t'(12'hFFF);
            fill_rand(rpx, rpy);
            run(rk, rpx, rpy, -1);
            wait_done(20000);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
